// File: rtl/ctrl_interrupciones_vec.sv
// Prioritised, vectored interrupt controller: latches edge/level requests, masks them,
// and injects a jump instruction for the highest-priority eligible channel until acked.
module ctrl_interrupciones_vec #(
    parameter int unsigned   N_IRQ    = 7,
    parameter int unsigned   IW       = 16,
    parameter logic [IW-1:0] VEC_BASE = 16'hEFFF,
    parameter logic [IW-1:0] VEC_STEP = 16'h0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             mode_we,
    input  logic [N_IRQ-1:0] mode_wdata,
    output logic             inj_valid,
    output logic [IW-1:0]    inj_instr,
    input  logic             inj_ack,
    input  logic             eoi,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service
);

    localparam int unsigned IDXW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t           r_state;
    logic [IDXW-1:0]  r_idx;
    logic             r_inj_valid;
    logic [IW-1:0]    r_inj_instr;
    logic [N_IRQ-1:0] r_mask;
    logic [N_IRQ-1:0] r_mode;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_in_service;
    logic [N_IRQ-1:0] r_irq_prev;

    logic             w_ack;
    logic [N_IRQ-1:0] w_ack_oh;
    logic [N_IRQ-1:0] w_elig;
    logic             w_blk;
    logic             w_any;
    logic [IDXW-1:0]  w_sel;
    logic [N_IRQ-1:0] w_eoi_clr;
    logic             w_eoi_done;
    logic [N_IRQ-1:0] w_pend_nxt;
    logic [N_IRQ-1:0] w_isr_nxt;
    logic [IW-1:0]    w_vec;

    assign w_ack    = (r_state == ST_REQ) && inj_ack;
    assign w_ack_oh = w_ack ? (N_IRQ'(1) << r_idx) : '0;
    assign w_vec    = VEC_BASE - IW'(w_sel) * VEC_STEP;

    // One pass: nesting block (any in-service bit at or above priority k), grant
    // selection, EOI target and per-channel pending update.
    always_comb begin
        w_blk      = 1'b0;
        w_elig     = '0;
        w_any      = 1'b0;
        w_sel      = '0;
        w_eoi_clr  = '0;
        w_eoi_done = 1'b0;
        w_pend_nxt = '0;
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            w_blk     = w_blk | r_in_service[k];
            w_elig[k] = r_pending[k] & ~r_mask[k] & ~w_blk;
            if (w_elig[k] && !w_any) begin
                w_any = 1'b1;
                w_sel = IDXW'(k);
            end
            if (r_in_service[k] && !w_eoi_done) begin
                w_eoi_done   = 1'b1;
                w_eoi_clr[k] = 1'b1;
            end
            if (r_mode[k])
                w_pend_nxt[k] = (irq_in[k] & ~r_irq_prev[k]) | (r_pending[k] & ~w_ack_oh[k]);
            else
                w_pend_nxt[k] = irq_in[k];
        end
    end

    // EOI acts on the pre-ack set, then the acked channel is added.
    assign w_isr_nxt = (r_in_service & ~(eoi ? w_eoi_clr : '0)) | w_ack_oh;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_inj_valid  <= 1'b0;
            r_inj_instr  <= '0;
            r_mask       <= '1;
            r_mode       <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_irq_prev   <= '0;
        end else begin
            r_irq_prev   <= irq_in;
            r_pending    <= w_pend_nxt;
            r_in_service <= w_isr_nxt;
            if (mask_we) r_mask <= mask_wdata;
            if (mode_we) r_mode <= mode_wdata;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state     <= ST_REQ;
                        r_idx       <= w_sel;
                        r_inj_valid <= 1'b1;
                        r_inj_instr <= w_vec;
                    end
                end
                ST_REQ: begin
                    if (inj_ack) begin
                        r_state     <= ST_IDLE;
                        r_inj_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign inj_valid  = r_inj_valid;
    assign inj_instr  = r_inj_instr;
    assign pending    = r_pending;
    assign in_service = r_in_service;

endmodule

// File: tb/tb_ctrl_interrupciones_vec.sv
// Directed bench for ctrl_interrupciones_vec: per-cycle vector table plus hand-written
// sequences for nesting, same-cycle ack/EOI/edge, level re-request and reset priority.
module tb_ctrl_interrupciones_vec;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  irq_in;
    logic        mask_we;
    logic [6:0]  mask_wdata;
    logic        mode_we;
    logic [6:0]  mode_wdata;
    logic        inj_valid;
    logic [15:0] inj_instr;
    logic        inj_ack;
    logic        eoi;
    logic [6:0]  pending;
    logic [6:0]  in_service;

    int checks   = 0;
    int failures = 0;

    ctrl_interrupciones_vec #(
        .N_IRQ   (7),
        .IW      (16),
        .VEC_BASE(16'hEFFF),
        .VEC_STEP(16'h0001)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .mode_we   (mode_we),
        .mode_wdata(mode_wdata),
        .inj_valid (inj_valid),
        .inj_instr (inj_instr),
        .inj_ack   (inj_ack),
        .eoi       (eoi),
        .pending   (pending),
        .in_service(in_service)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [6:0]  irq;
        logic        mwe;
        logic [6:0]  mw;
        logic        dwe;
        logic [6:0]  dw;
        logic        ack;
        logic        eo;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [6:0]  e_pend;
        logic [6:0]  e_isr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [6:0] irq, logic mwe, logic [6:0] mw,
                                logic dwe, logic [6:0] dw, logic ack, logic eo,
                                logic ev, logic [15:0] ei, logic [6:0] ep, logic [6:0] es);
        vec_t v;
        v.rst = rst; v.irq = irq; v.mwe = mwe; v.mw = mw; v.dwe = dwe; v.dw = dw;
        v.ack = ack; v.eo = eo; v.e_valid = ev; v.e_instr = ei; v.e_pend = ep; v.e_isr = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        reset = 1'b0; mask_we = 1'b0; mode_we = 1'b0; inj_ack = 1'b0; eoi = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
        mode_we = 1'b0; mode_wdata = '0; inj_ack = 1'b0; eoi = 1'b0;

        //            rst irq    mwe mw     dwe dw     ack eoi  v  instr     pend   isr
        tbl.push_back(mk(1, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0,  0, 16'h0000, 7'h00, 7'h00));
        tbl.push_back(mk(0, 7'h00, 1, 7'h00, 1, 7'h04, 0, 0,  0, 16'h0000, 7'h00, 7'h00));
        tbl.push_back(mk(0, 7'h04, 0, 7'h00, 0, 7'h00, 0, 0,  0, 16'h0000, 7'h04, 7'h00));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0,  1, 16'hEFFD, 7'h04, 7'h00));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0,  1, 16'hEFFD, 7'h04, 7'h00));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 1, 0,  0, 16'hEFFD, 7'h00, 7'h04));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 1,  0, 16'hEFFD, 7'h00, 7'h00));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 1, 7'h16, 0, 0,  0, 16'hEFFD, 7'h00, 7'h00));
        tbl.push_back(mk(0, 7'h12, 0, 7'h00, 0, 7'h00, 0, 0,  0, 16'hEFFD, 7'h12, 7'h00));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0,  1, 16'hEFFE, 7'h12, 7'h00));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 1, 0,  0, 16'hEFFE, 7'h10, 7'h02));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0,  0, 16'hEFFE, 7'h10, 7'h02));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 1,  0, 16'hEFFE, 7'h10, 7'h00));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0,  1, 16'hEFFB, 7'h10, 7'h00));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 1, 0,  0, 16'hEFFB, 7'h00, 7'h10));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 1,  0, 16'hEFFB, 7'h00, 7'h00));
        tbl.push_back(mk(0, 7'h00, 1, 7'h40, 1, 7'h56, 0, 0,  0, 16'hEFFB, 7'h00, 7'h00));
        tbl.push_back(mk(0, 7'h40, 0, 7'h00, 0, 7'h00, 0, 0,  0, 16'hEFFB, 7'h40, 7'h00));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0,  0, 16'hEFFB, 7'h40, 7'h00));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0,  0, 16'hEFFB, 7'h40, 7'h00));
        tbl.push_back(mk(0, 7'h00, 1, 7'h00, 0, 7'h00, 0, 0,  0, 16'hEFFB, 7'h40, 7'h00));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0,  1, 16'hEFF9, 7'h40, 7'h00));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 1, 0,  0, 16'hEFF9, 7'h00, 7'h40));
        tbl.push_back(mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 0, 1,  0, 16'hEFF9, 7'h00, 7'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; irq_in = tbl[i].irq;
            mask_we = tbl[i].mwe; mask_wdata = tbl[i].mw;
            mode_we = tbl[i].dwe; mode_wdata = tbl[i].dw;
            inj_ack = tbl[i].ack; eoi = tbl[i].eo;
            step();
            chk($sformatf("row%0d.valid", i), 32'(inj_valid),  32'(tbl[i].e_valid));
            chk($sformatf("row%0d.instr", i), 32'(inj_instr),  32'(tbl[i].e_instr));
            chk($sformatf("row%0d.pend", i),  32'(pending),    32'(tbl[i].e_pend));
            chk($sformatf("row%0d.isr", i),   32'(in_service), 32'(tbl[i].e_isr));
        end
        clr(); irq_in = '0;

        // Nesting: ch3 in service, ch0 preempts, ch5 waits for two EOIs
        mode_we = 1'b1; mode_wdata = 7'h7F; step(); clr();
        irq_in = 7'h08; step(); chk("t3.pend3", 32'(pending), 32'h08);
        irq_in = 7'h00; step(); chk("t3.v3", 32'(inj_valid), 1); chk("t3.i3", 32'(inj_instr), 32'hEFFC);
        inj_ack = 1'b1; step(); clr(); chk("t3.isr3", 32'(in_service), 32'h08);
        irq_in = 7'h01; step();
        irq_in = 7'h00; step(); chk("t3.v0", 32'(inj_valid), 1); chk("t3.i0", 32'(inj_instr), 32'hEFFF);
        inj_ack = 1'b1; step(); clr(); chk("t3.isr30", 32'(in_service), 32'h09);
        irq_in = 7'h20; step(); irq_in = 7'h00;
        for (int i = 0; i < 4; i++) begin
            step(); chk("t3.wait5", 32'(inj_valid), 0);
        end
        eoi = 1'b1; step(); clr(); chk("t3.eoi1", 32'(in_service), 32'h08);
        step(); chk("t3.still_blocked", 32'(inj_valid), 0);
        eoi = 1'b1; step(); clr(); chk("t3.eoi2", 32'(in_service), 32'h00);
        step(); chk("t3.v5", 32'(inj_valid), 1); chk("t3.i5", 32'(inj_instr), 32'hEFFA);
        inj_ack = 1'b1; step(); clr(); chk("t3.pend5", 32'(pending), 0); chk("t3.isr5", 32'(in_service), 32'h20);
        eoi = 1'b1; step(); clr();

        // Same-cycle ack + EOI + fresh edge on the granted channel
        irq_in = 7'h08; step(); irq_in = 7'h00; step();
        inj_ack = 1'b1; step(); clr();
        irq_in = 7'h01; step(); irq_in = 7'h00; step();
        chk("t7.v0", 32'(inj_valid), 1);
        inj_ack = 1'b1; eoi = 1'b1; irq_in = 7'h01; step(); clr(); irq_in = 7'h00;
        chk("t7.isr", 32'(in_service), 32'h01); chk("t7.pend", 32'(pending), 32'h01);
        step(); chk("t7.blocked", 32'(inj_valid), 0);
        eoi = 1'b1; step(); clr(); chk("t7.eoi", 32'(in_service), 0);
        step(); chk("t7.regrant", 32'(inj_valid), 1); chk("t7.i0", 32'(inj_instr), 32'hEFFF);
        inj_ack = 1'b1; step(); clr(); chk("t7.pend_clr", 32'(pending), 0);
        eoi = 1'b1; step(); clr();

        // Edge->level mode change discards latched edge; then level re-request
        mask_we = 1'b1; mask_wdata = 7'h7F; step(); clr();
        irq_in = 7'h40; step(); chk("t5.pend6", 32'(pending), 32'h40);
        irq_in = 7'h00; step();
        mode_we = 1'b1; mode_wdata = 7'h00; step(); clr(); chk("t5.pend_keep", 32'(pending), 32'h40);
        step(); chk("t5.pend_drop", 32'(pending), 0);
        mask_we = 1'b1; mask_wdata = 7'h00; step(); clr();
        irq_in = 7'h04; step(); chk("t5.lvl_pend", 32'(pending), 32'h04);
        step(); chk("t5.v1", 32'(inj_valid), 1); chk("t5.i1", 32'(inj_instr), 32'hEFFD);
        inj_ack = 1'b1; step(); clr();
        chk("t5.isr", 32'(in_service), 32'h04); chk("t5.pend_ack", 32'(pending), 32'h04);
        step(); chk("t5.blocked", 32'(inj_valid), 0);
        eoi = 1'b1; step(); clr(); chk("t5.eoi", 32'(in_service), 0);
        step(); chk("t5.v2", 32'(inj_valid), 1);
        inj_ack = 1'b1; step(); clr();
        eoi = 1'b1; step(); clr();
        step(); chk("t5.v3", 32'(inj_valid), 1);

        // Reset beats a simultaneous ack while in REQ
        reset = 1'b1; inj_ack = 1'b1; step(); clr();
        chk("t6.valid", 32'(inj_valid), 0); chk("t6.instr", 32'(inj_instr), 0);
        chk("t6.pend", 32'(pending), 0);    chk("t6.isr", 32'(in_service), 0);
        step(); chk("t6.lvl_pend", 32'(pending), 32'h04);
        for (int i = 0; i < 3; i++) begin
            step(); chk("t6.masked", 32'(inj_valid), 0);
        end
        irq_in = 7'h00; step(); chk("t5.drop", 32'(pending), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
